tlight_sched: RTL and testbench
===============================

Name: tlight_sched

Overview:
- Demand-responsive phase scheduler for a two-way intersection (NS and WE approaches).
- Sequences green/yellow/all-red phases from vehicle sensors and latched pedestrian buttons, with minimum and maximum green times.
- Supports emergency preemption toward a selected direction.
- Drives the lamp buses `ns`/`we` directly; replaces fixed-duration sequencing at the intersection top level.

Parameters:
- GREEN_MIN, 16, minimum green duration in cycles (>=2)
- GREEN_MAX, 32, maximum green duration when both directions demand (> GREEN_MIN)
- YELLOW, 4, yellow duration in cycles (>=1)
- ALLRED, 2, all-red clearance duration in cycles (>=1)
- CW, 6, phase counter width; must hold GREEN_MAX-1

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- demand_ns  in  1  NS vehicle sensor, level
- demand_we  in  1  WE vehicle sensor, level
- ped_ns  in  1  NS pedestrian button, single-cycle pulse
- ped_we  in  1  WE pedestrian button, single-cycle pulse
- emerg  in  1  emergency preempt request, level
- emerg_dir  in  1  preempt direction: 0 = NS, 1 = WE
- ns  out  3  NS lamps {red,yellow,green}: 100 / 010 / 001
- we  out  3  WE lamps, same encoding
- walk_ns  out  1  NS pedestrian walk
- walk_we  out  1  WE pedestrian walk
- emerg_ack  out  1  preempt direction currently green
- phase  out  3  current state encoding, for debug

Behaviour:
- States and encodings: NS_G=0, NS_Y=1, AR_A=2, WE_G=3, WE_Y=4, AR_B=5.
- Phase counter `cnt`:
  - Cleared to 0 on every state entry; +1 each cycle while the state holds.
  - A state of duration D is left at the edge where cnt==D-1, so it lasts exactly D cycles.
- Lamp outputs per state:
  - NS_G: ns=001, we=100. NS_Y: ns=010, we=100.
  - WE_G: ns=100, we=001. WE_Y: ns=100, we=010.
  - AR_A / AR_B: both 100.
  - `ns` and `we` are never both non-red.
- Outputs are registered or decoded from state only; no combinational path from any input.
- Reset (reset==0 at an edge):
  - state=AR_B, cnt=0; ns=we=100; walk_ns=walk_we=0; emerg_ack=0.
  - Pedestrian latches are cleared.
  - Reset mid-operation takes effect at that edge regardless of state.
  - After release: AR_B for ALLRED cycles, then NS_G.
- Pedestrian latches:
  - ped_x pulse sets lat_x.
  - lat_x clears on the edge entering X_G; walk_x=1 for the whole X_G state.
  - A pulse arriving during X_G sets the latch for the next X_G.
  - Set and clear on the same edge: set wins.
- Definitions: cross request in NS_G: xreq = demand_we | lat_we. In WE_G: xreq = demand_ns | lat_ns.
- NS_G (WE_G symmetric) without preemption:
  - Stay while cnt < GREEN_MIN-1.
  - At cnt >= GREEN_MIN-1, go to NS_Y if xreq and (!demand_ns or cnt==GREEN_MAX-1).
  - Otherwise stay, resting in green indefinitely with no cross request.
  - cnt saturates at GREEN_MAX-1.
- Yellow and all-red timing:
  - NS_Y lasts YELLOW cycles, then AR_A. AR_A lasts ALLRED cycles, then the next green.
  - WE_Y to AR_B is symmetric.
- Next green after all-red: emerg ? (emerg_dir ? WE_G : NS_G) : alternate direction.
- Preemption while emerg==1:
  - In the conflicting green: go to its yellow on the next edge, ignoring GREEN_MIN.
  - In the preempt-direction green: hold; normal exit rules are suspended.
  - Yellow and all-red states always complete their full duration.
- emerg_ack=1 when in the emerg_dir green and emerg==1; registered, so it is valid from the first cycle of that green.
- When emerg drops: normal rules resume with the existing cnt. If cnt already >= GREEN_MIN-1, exit is evaluated on the next edge.
- emerg_dir change while emerg==1 is treated as a new preempt toward the new direction.

Test Plan:
(GREEN_MIN=8, GREEN_MAX=20, YELLOW=3, ALLRED=2, CW=5)
1. Reset 3 cycles, then no inputs -> ns=we=100 for 2 cycles, then ns=001 / we=100 held for 50+ cycles; phase=0.
2. demand_we=1 from reset release, demand_ns=0 -> NS_G exactly 8 cycles, NS_Y 3, AR_A 2, then WE_G held indefinitely (no NS request).
3. demand_ns=demand_we=1 continuously -> NS_G 20 cycles, NS_Y 3, AR_A 2, WE_G 20, WE_Y 3, AR_B 2, repeating with period 50.
4. ped_we pulse at NS_G cnt=2, no vehicles -> NS_G ends after 8 cycles; walk_we=1 for the entire following WE_G; lat_we cleared; WE_G then rests.
5. In WE_G at cnt=3 (demand_we=1), emerg=1 with emerg_dir=0 -> next cycle WE_Y (3 cycles), AR_B (2), NS_G with emerg_ack=1 held 30 cycles while emerg=1. emerg drops -> NS_Y on the next edge (cnt>=7, demand_we=1).
6. reset=0 during WE_Y cnt=1 -> next cycle ns=we=100, walk 0, latches cleared; after release AR_B 2 cycles, then NS_G.

Source files
------------

// File: rtl/tlight_sched.sv
// rtl/tlight_sched.sv - demand-responsive two-way intersection phase scheduler
module tlight_sched #(
  parameter int GREEN_MIN = 16,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW    = 4,
  parameter int ALLRED    = 2,
  parameter int CW        = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       demand_ns,
  input  logic       demand_we,
  input  logic       ped_ns,
  input  logic       ped_we,
  input  logic       emerg,
  input  logic       emerg_dir,
  output logic [2:0] ns,
  output logic [2:0] we,
  output logic       walk_ns,
  output logic       walk_we,
  output logic       emerg_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    WE_G = 3'd3,
    WE_Y = 3'd4,
    AR_B = 3'd5
  } state_t;

  localparam logic [CW-1:0] GMIN_L = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_L = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_L  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_L   = CW'(ALLRED - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          lat_ns;
  logic          lat_we;
  logic          walk_ns_q;
  logic          walk_we_q;
  logic          ack_q;
  logic          in_green;
  logic          enter_ns_g;
  logic          enter_we_g;

  assign in_green   = (state == NS_G) || (state == WE_G);
  assign enter_ns_g = (state_n == NS_G) && (state != NS_G);
  assign enter_we_g = (state_n == WE_G) && (state != WE_G);

  // next-state: preemption overrides green timing, yellow/all-red always run to completion
  always_comb begin
    state_n = state;
    case (state)
      NS_G: begin
        if (emerg) begin
          if (emerg_dir) state_n = NS_Y;
        end else if (cnt >= GMIN_L && (demand_we || lat_we) &&
                     (!demand_ns || cnt == GMAX_L)) begin
          state_n = NS_Y;
        end
      end
      NS_Y: if (cnt == YEL_L) state_n = AR_A;
      AR_A: if (cnt == AR_L) state_n = emerg ? (emerg_dir ? WE_G : NS_G) : WE_G;
      WE_G: begin
        if (emerg) begin
          if (!emerg_dir) state_n = WE_Y;
        end else if (cnt >= GMIN_L && (demand_ns || lat_ns) &&
                     (!demand_we || cnt == GMAX_L)) begin
          state_n = WE_Y;
        end
      end
      WE_Y: if (cnt == YEL_L) state_n = AR_B;
      AR_B: if (cnt == AR_L) state_n = emerg ? (emerg_dir ? WE_G : NS_G) : NS_G;
      default: state_n = AR_B;
    endcase
  end

  // state, phase counter, pedestrian latches and registered walk/ack flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= AR_B;
      cnt       <= '0;
      lat_ns    <= 1'b0;
      lat_we    <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_we_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        cnt <= '0;
      end else if (!(in_green && cnt == GMAX_L)) begin
        cnt <= cnt + 1'b1;
      end
      // a new press on the clearing edge keeps the latch set for the next green
      lat_ns    <= ped_ns | (lat_ns & ~enter_ns_g);
      lat_we    <= ped_we | (lat_we & ~enter_we_g);
      walk_ns_q <= (state_n == NS_G) && ((state == NS_G) ? walk_ns_q : lat_ns);
      walk_we_q <= (state_n == WE_G) && ((state == WE_G) ? walk_we_q : lat_we);
      ack_q     <= emerg && (((state_n == NS_G) && !emerg_dir) ||
                             ((state_n == WE_G) &&  emerg_dir));
    end
  end

  // lamp decode from state only
  always_comb begin
    ns = 3'b100;
    we = 3'b100;
    case (state)
      NS_G: ns = 3'b001;
      NS_Y: ns = 3'b010;
      WE_G: we = 3'b001;
      WE_Y: we = 3'b010;
      default: ;
    endcase
  end

  assign walk_ns   = walk_ns_q;
  assign walk_we   = walk_we_q;
  assign emerg_ack = ack_q;
  assign phase     = state;

endmodule

// File: tb/tb_tlight_sched.sv
// tb/tb_tlight_sched.sv - directed self-checking bench for tlight_sched
module tb_tlight_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       demand_ns;
  logic       demand_we;
  logic       ped_ns;
  logic       ped_we;
  logic       emerg;
  logic       emerg_dir;
  logic [2:0] ns;
  logic [2:0] we;
  logic       walk_ns;
  logic       walk_we;
  logic       emerg_ack;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  tlight_sched #(
    .GREEN_MIN(8), .GREEN_MAX(20), .YELLOW(3), .ALLRED(2), .CW(5)
  ) dut (
    .clock(clock), .reset(reset),
    .demand_ns(demand_ns), .demand_we(demand_we),
    .ped_ns(ped_ns), .ped_we(ped_we),
    .emerg(emerg), .emerg_dir(emerg_dir),
    .ns(ns), .we(we),
    .walk_ns(walk_ns), .walk_we(walk_we),
    .emerg_ack(emerg_ack), .phase(phase)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // expected lamps per phase encoding
  function automatic logic [2:0] exp_ns(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_we(input logic [2:0] ph);
    case (ph)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // check n consecutive cycles in phase ph; fl = {emerg_ack, walk_ns, walk_we}
  task automatic hold(input string tag, input logic [2:0] ph, input int n, input logic [2:0] fl);
    for (int i = 0; i < n; i++) begin
      check({tag, ".phase"}, 8'(phase), 8'(ph));
      check({tag, ".ns"}, 8'(ns), 8'(exp_ns(ph)));
      check({tag, ".we"}, 8'(we), 8'(exp_we(ph)));
      check({tag, ".walk_ns"}, 8'(walk_ns), 8'(fl[1]));
      check({tag, ".walk_we"}, 8'(walk_we), 8'(fl[0]));
      check({tag, ".ack"}, 8'(emerg_ack), 8'(fl[2]));
      step();
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".phase"}, 8'(phase), 8'd5);
    check({tag, ".ns"}, 8'(ns), 8'b100);
    check({tag, ".we"}, 8'(we), 8'b100);
    check({tag, ".walk_ns"}, 8'(walk_ns), 8'd0);
    check({tag, ".walk_we"}, 8'(walk_we), 8'd0);
    check({tag, ".ack"}, 8'(emerg_ack), 8'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    repeat (3) step();
    reset_checks(tag);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; demand_ns = 0; demand_we = 0;
    ped_ns = 0; ped_we = 0; emerg = 0; emerg_dir = 0;

    // 1: idle after reset rests in NS green
    do_reset("t1.rst");
    hold("t1.arb", 3'd5, 2, 3'b000);
    hold("t1.nsg", 3'd0, 50, 3'b000);

    // 2: only WE demand -> minimum NS green then WE rests
    demand_we = 1;
    do_reset("t2.rst");
    hold("t2.arb", 3'd5, 2, 3'b000);
    hold("t2.nsg", 3'd0, 8, 3'b000);
    hold("t2.nsy", 3'd1, 3, 3'b000);
    hold("t2.ara", 3'd2, 2, 3'b000);
    hold("t2.weg", 3'd3, 30, 3'b000);

    // 3: both demands -> max-green alternation, period 50
    demand_ns = 1; demand_we = 1;
    do_reset("t3.rst");
    hold("t3.arb0", 3'd5, 2, 3'b000);
    for (int k = 0; k < 2; k++) begin
      hold("t3.nsg", 3'd0, 20, 3'b000);
      hold("t3.nsy", 3'd1, 3, 3'b000);
      hold("t3.ara", 3'd2, 2, 3'b000);
      hold("t3.weg", 3'd3, 20, 3'b000);
      hold("t3.wey", 3'd4, 3, 3'b000);
      hold("t3.arb", 3'd5, 2, 3'b000);
    end

    // 4: WE pedestrian pulse at NS_G cnt=2, no vehicles
    demand_ns = 0; demand_we = 0;
    do_reset("t4.rst");
    hold("t4.arb", 3'd5, 2, 3'b000);
    hold("t4.nsg0", 3'd0, 2, 3'b000);
    ped_we = 1;
    hold("t4.nsg2", 3'd0, 1, 3'b000);
    ped_we = 0;
    hold("t4.nsg3", 3'd0, 5, 3'b000);
    hold("t4.nsy", 3'd1, 3, 3'b000);
    hold("t4.ara", 3'd2, 2, 3'b000);
    hold("t4.weg", 3'd3, 25, 3'b001);

    // 5: preempt toward NS from WE_G cnt=3
    demand_we = 1;
    do_reset("t5.rst");
    hold("t5.arb", 3'd5, 2, 3'b000);
    hold("t5.nsg", 3'd0, 8, 3'b000);
    hold("t5.nsy", 3'd1, 3, 3'b000);
    hold("t5.ara", 3'd2, 2, 3'b000);
    hold("t5.weg", 3'd3, 3, 3'b000);
    emerg = 1; emerg_dir = 0;
    hold("t5.weg3", 3'd3, 1, 3'b000);
    hold("t5.wey", 3'd4, 3, 3'b000);
    hold("t5.arb2", 3'd5, 2, 3'b000);
    hold("t5.nsg_e", 3'd0, 30, 3'b100);
    emerg = 0;
    hold("t5.nsg_drop", 3'd0, 1, 3'b100);
    hold("t5.nsy2", 3'd1, 3, 3'b000);
    hold("t5.ara2", 3'd2, 2, 3'b000);
    hold("t5.weg2", 3'd3, 5, 3'b000);

    // 6: reset during WE_Y cnt=1 clears pending NS pedestrian latch
    demand_ns = 0; demand_we = 1;
    do_reset("t6.rst");
    hold("t6.arb", 3'd5, 2, 3'b000);
    hold("t6.nsg", 3'd0, 8, 3'b000);
    hold("t6.nsy", 3'd1, 3, 3'b000);
    hold("t6.ara", 3'd2, 2, 3'b000);
    demand_we = 0; ped_ns = 1;
    hold("t6.weg0", 3'd3, 1, 3'b000);
    ped_ns = 0;
    hold("t6.weg", 3'd3, 7, 3'b000);
    hold("t6.wey0", 3'd4, 1, 3'b000);
    reset = 0; ped_we = 1;
    step();
    ped_we = 0;
    reset_checks("t6.midrst");
    reset = 1;
    hold("t6.arb2", 3'd5, 2, 3'b000);
    hold("t6.nsg2", 3'd0, 20, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
